pong_object: RTL and testbench
==============================

# pong_object

Renders one moving square "ball" for the Pong video pipeline. Each pixel clock it compares the raster position (`hpos`, `vpos`) against the ball's bounding box and drives a colour plus an `active` flag that the downstream mixer uses to overlay the object. Once per frame, marked by `fsync`, the ball advances by a fixed step and bounces off the screen edges.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: visible width in pixels.
- `V_ACTIVE`, default 720: visible height in lines.
- `SIZE`, default 16: ball side length in pixels.
- `X_START`, default 632: reset x of the ball's top-left corner.
- `Y_START`, default 352: reset y of the ball's top-left corner.
- `X_STEP`, default 2: horizontal pixels moved per frame.
- `Y_STEP`, default 2: vertical pixels moved per frame.
- `COLOR_R`, `COLOR_G`, `COLOR_B`, default 8'hFF each: ball colour.

Ports:
- `pixel_clk` in 1: the only clock. All logic runs on its rising edge.
- `rst` in 1: reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- `fsync` in 1: frame sync level. Each rising edge is one frame tick.
- `hpos` in 12: current raster column.
- `vpos` in 12: current raster line.
- `pixel` out 3x8 (unpacked `[0:2]`): [0]=R, [1]=G, [2]=B.
- `active` out 1: 1 when the current raster position is inside the ball.

## Operation
- State:
  - 12-bit `x`, `y` for the top-left corner.
  - Direction bits `dx` and `dy` (1 = increasing).
  - `fsync_q` for edge detection.
- Reset values:
  - `x=X_START`, `y=Y_START`, `dx=1`, `dy=1`, `fsync_q=0`.
  - `active=0`, `pixel={0,0,0}`.
- Frame tick:
  - Occurs when `fsync & ~fsync_q`.
  - Holding `fsync` high moves the ball exactly once.
  - Because `fsync_q` resets to 0, `fsync` already high when reset releases produces a tick on the first edge.
- Horizontal move on a tick:
  - If `dx=1`: when `x+X_STEP >= H_ACTIVE-SIZE`, set `x=H_ACTIVE-SIZE` and `dx=0`. Otherwise `x=x+X_STEP`.
  - If `dx=0`: when `x <= X_STEP`, set `x=0` and `dx=1`. Otherwise `x=x-X_STEP`.
- Vertical move: identical to horizontal, using `y`, `dy`, `Y_STEP` and `V_ACTIVE`.
- Horizontal and vertical bounces are independent. A corner hit flips both bits on the same tick.
- Hit test:
  - Hit when `x <= hpos < x+SIZE` and `y <= vpos < y+SIZE`.
  - Compare unsigned at 13 bits so `x+SIZE` cannot wrap.
  - The test uses the `x`/`y` value held before the current edge's update.
- Output:
  - `active <= hit`.
  - `pixel <= hit ? {COLOR_R,COLOR_G,COLOR_B} : {0,0,0}`.
- Positions outside the visible area (`hpos >= H_ACTIVE` or `vpos >= V_ACTIVE`) never hit, because the box always lies inside the visible area.

## Timing
- `active` and `pixel` are registered, with 1 `pixel_clk` latency from `hpos`/`vpos`.
- A frame tick on edge N changes position after edge N. The hit test uses the new position from edge N+1, with the output visible after edge N+1.
- Asynchronous reset: `active` and `pixel` go to 0, and position and direction return to their reset values, without waiting for a clock edge (within 1 ns in simulation).
- Reset mid-operation discards the current position and direction. The first tick after release moves from `X_START`, `Y_START`.
- No other handshakes. `hpos` and `vpos` are sampled every cycle.

## Test plan
- Reset check:
  - Assert `rst` with no clock edge.
  - Within 1 ns, `active=0` and `pixel=0`.
- Outside point:
  - After reset, with `fsync=0`, drive `hpos=500`, `vpos=500`.
  - Required: `active=0` and `pixel={0,0,0}` next cycle.
- Inside and edges (`fsync=0`):
  - `hpos=632`, `vpos=352`: `active=1`, pixel FF/FF/FF one cycle later.
  - `hpos=647`, `vpos=367`: `active=1`.
  - `hpos=648`, `vpos=352`: `active=0`.
  - `hpos=632`, `vpos=368`: `active=0`.
- Single move:
  - Hold `fsync=1` for 100 cycles. Exactly one tick occurs, moving the ball to (634,354).
  - `hpos=633`, `vpos=360`: `active=0`.
  - `hpos=649`, `vpos=369`: `active=1`.
- Bounce:
  - Set `X_START=1262`.
  - Tick 1: `x=1264`, `dx` flips to 0.
  - Tick 2: `x=1262`.
  - With `Y_START=1`, tick 1 gives `y=0` and `dy=0`? No: with `dy=1` it gives `y=3`. Start instead with the direction reversed via an earlier bounce and check the clamp to 0.
- Mid-run reset:
  - Pulse `rst` after 3 ticks.
  - Position returns to (632,352).
  - The next tick gives (634,354).

Source files
------------

// File: rtl/pong_object.sv
// One square "ball" sprite: registered hit test against the raster position,
// plus a once-per-frame move that bounces off the visible-area edges.
module pong_object #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int SIZE     = 16,
  parameter int X_START  = 632,
  parameter int Y_START  = 352,
  parameter int X_STEP   = 2,
  parameter int Y_STEP   = 2,
  parameter logic [7:0] COLOR_R = 8'hFF,
  parameter logic [7:0] COLOR_G = 8'hFF,
  parameter logic [7:0] COLOR_B = 8'hFF
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        fsync,
  input  logic [11:0] hpos,
  input  logic [11:0] vpos,
  output logic [7:0]  pixel [0:2],
  output logic        active
);

  // Interface timing: there is no valid/ready pair. hpos/vpos are taken on
  // every rising pixel_clk edge and active/pixel describe that position one
  // edge later; fsync is a level whose rising edge is one frame tick.

  localparam logic [12:0] X_MAX  = 13'(H_ACTIVE - SIZE);
  localparam logic [12:0] Y_MAX  = 13'(V_ACTIVE - SIZE);
  localparam logic [12:0] X_STP  = 13'(X_STEP);
  localparam logic [12:0] Y_STP  = 13'(Y_STEP);
  localparam logic [12:0] SIZE13 = 13'(SIZE);

  logic [11:0] x, y;
  logic        dx, dy;
  logic        fsync_q;
  logic        tick;
  logic        hit;
  logic [12:0] x_upd, y_upd;

  // Returns {new_dir, new_pos}; the far wall clamps to lim, the near wall to 0.
  function automatic logic [12:0] step_axis(input logic [11:0] p,
                                            input logic        d,
                                            input logic [12:0] step,
                                            input logic [12:0] lim);
    logic [12:0] p13;
    logic [12:0] sum;
    logic [12:0] res;
    p13 = {1'b0, p};
    sum = p13 + step;
    if (d) begin
      if (sum >= lim) res = {1'b0, lim[11:0]};
      else            res = {1'b1, sum[11:0]};
    end else begin
      if (p13 <= step) res = {1'b1, 12'd0};
      else             res = {1'b0, p - step[11:0]};
    end
    return res;
  endfunction

  always_comb begin
    tick  = fsync & ~fsync_q;
    x_upd = step_axis(x, dx, X_STP, X_MAX);
    y_upd = step_axis(y, dy, Y_STP, Y_MAX);
    hit   = ({1'b0, hpos} >= {1'b0, x}) && ({1'b0, hpos} < ({1'b0, x} + SIZE13)) &&
            ({1'b0, vpos} >= {1'b0, y}) && ({1'b0, vpos} < ({1'b0, y} + SIZE13));
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      x       <= 12'(X_START);
      y       <= 12'(Y_START);
      dx      <= 1'b1;
      dy      <= 1'b1;
      fsync_q <= 1'b0;
    end else begin
      fsync_q <= fsync;
      if (tick) begin
        x  <= x_upd[11:0];
        dx <= x_upd[12];
        y  <= y_upd[11:0];
        dy <= y_upd[12];
      end
    end
  end

  // Hit uses the position held before this edge's move.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      pixel[0] <= 8'h00;
      pixel[1] <= 8'h00;
      pixel[2] <= 8'h00;
    end else begin
      active   <= hit;
      pixel[0] <= hit ? COLOR_R : 8'h00;
      pixel[1] <= hit ? COLOR_G : 8'h00;
      pixel[2] <= hit ? COLOR_B : 8'h00;
    end
  end

endmodule

// File: tb/tb_pong_object.sv
// Bench for pong_object: driver pushes expected {active,R,G,B} from an
// integer-arithmetic ball model; monitor pops and compares every cycle.
module tb_pong_object;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int SIZE     = 16;
  localparam int X_START  = 632;
  localparam int Y_START  = 352;
  localparam int X_STEP   = 2;
  localparam int Y_STEP   = 2;
  localparam int W        = 25;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fsync = 1'b0;
  logic [11:0] hpos = 12'd0;
  logic [11:0] vpos = 12'd0;
  logic [7:0]  pixel [0:2];
  logic        active;

  always #5 clk = ~clk;

  pong_object dut (
    .pixel_clk(clk),
    .rst      (rst),
    .fsync    (fsync),
    .hpos     (hpos),
    .vpos     (vpos),
    .pixel    (pixel),
    .active   (active)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: position, direction as +1/-1, last fsync level
  int mx, my, mdx, mdy;
  bit mfs;
  int n_ticks = 0;
  int hits_seen = 0;
  int x_min = 99999, x_max = -1, y_min = 99999, y_max = -1;

  function automatic logic [W-1:0] act_word();
    return {active, pixel[0], pixel[1], pixel[2]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, req, $time);
  endtask

  task automatic model_reset();
    mx = X_START; my = Y_START; mdx = 1; mdy = 1; mfs = 1'b0;
  endtask

  task automatic model_move(inout int p, inout int d, input int step, input int span);
    if (d > 0) begin
      if (p + step >= span - SIZE) begin p = span - SIZE; d = -1; end
      else p = p + step;
    end else begin
      if (p <= step) begin p = 0; d = 1; end
      else p = p - step;
    end
  endtask

  // Drive inputs now (called at a negedge) and predict the next edge's output.
  task automatic apply(input int h, input int v, input bit fs);
    bit hit;
    hpos  = 12'(h);
    vpos  = 12'(v);
    fsync = fs;
    hit = (h >= mx) && (h < mx + SIZE) && (v >= my) && (v < my + SIZE) &&
          (h < 4096) && (v < 4096);
    if (hit) hits_seen++;
    exp_q.push_back(hit ? {1'b1, 24'hFFFFFF} : {1'b0, 24'h000000});
    if (fs && !mfs) begin
      model_move(mx, mdx, X_STEP, H_ACTIVE);
      model_move(my, mdy, Y_STEP, V_ACTIVE);
      n_ticks++;
      if (mx < x_min) x_min = mx;
      if (mx > x_max) x_max = mx;
      if (my < y_min) y_min = my;
      if (my > y_max) y_max = my;
    end
    mfs = fs;
  endtask

  task automatic cyc(input int h, input int v, input bit fs);
    @(negedge clk);
    apply(h, v, fs);
  endtask

  // Probe a point near the ball's current corner so edges get exercised.
  task automatic probe(input bit fs);
    int h, v;
    if ($urandom_range(0, 7) == 0) begin
      h = $urandom_range(0, 1400);
      v = $urandom_range(0, 800);
    end else begin
      h = mx + $urandom_range(0, SIZE + 3) - 2;
      v = my + $urandom_range(0, SIZE + 3) - 2;
      if (h < 0) h = 4095;
      if (v < 0) v = 4095;
    end
    cyc(h, v, fs);
  endtask

  // Async reset mid-cycle; release at a negedge with fsync at fs_rel.
  task automatic do_reset(input bit fs_rel, input int h, input int v);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", act_word(), '0);
    fsync = fs_rel;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_hold", act_word(), '0);
    rst = 1'b0;
    apply(h, v, fs_rel);
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel_out", act_word(), e);
      end
    end
  end

  initial begin
    bit fs;
    model_reset();
    // reset before any clock edge, outputs checked 1 ns after assertion
    #2 rst = 1'b1;
    #1 check("reset_no_clock", act_word(), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(500, 500, 1'b0);

    // static hit tests at the reset position
    cyc(632, 352, 1'b0);
    cyc(647, 367, 1'b0);
    cyc(648, 352, 1'b0);
    cyc(632, 368, 1'b0);
    cyc(631, 360, 1'b0);
    cyc(640, 351, 1'b0);
    cyc(1290, 360, 1'b0);

    // held fsync: one tick only, ball at (634,354)
    for (int i = 0; i < 100; i++) probe(1'b1);
    cyc(633, 360, 1'b1);
    cyc(649, 369, 1'b1);
    cyc(634, 354, 1'b1);
    cyc(650, 354, 1'b0);

    // mid-run reset after three ticks
    for (int i = 0; i < 3; i++) begin
      cyc(mx, my, 1'b1);
      cyc(mx + SIZE - 1, my + SIZE - 1, 1'b0);
    end
    cyc(mx, my, 1'b0);
    do_reset(1'b0, 632, 352);
    cyc(633, 353, 1'b1);
    cyc(633, 353, 1'b0);
    cyc(634, 354, 1'b0);
    cyc(633, 369, 1'b0);

    // fsync already high at release ticks on the first edge
    do_reset(1'b1, 632, 352);
    cyc(633, 353, 1'b1);
    cyc(634, 354, 1'b1);

    // long random run: frequent ticks drive the ball through all four walls
    fs = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) != 0) fs = ~fs;
      probe(fs);
    end

    // pin exact corner/edge pixels at the final position
    cyc(mx, my, 1'b0);
    cyc(mx + SIZE - 1, my, 1'b0);
    cyc(mx + SIZE, my, 1'b0);
    cyc(mx, my + SIZE, 1'b0);
    repeat (3) @(negedge clk);

    n_checks++;
    if (x_min == 0 && x_max == H_ACTIVE - SIZE && y_min == 0 && y_max == V_ACTIVE - SIZE &&
        hits_seen > 100 && exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL coverage: x %0d..%0d y %0d..%0d hits %0d left %0d (need walls 0/%0d 0/%0d)",
               x_min, x_max, y_min, y_max, hits_seen, exp_q.size(),
               H_ACTIVE - SIZE, V_ACTIVE - SIZE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
